piso_tx_ctrl: RTL

- Frame sequencer for the 4-bit PISO shift register.
- Accepts parallel words over a valid/ready handshake, drives the PISO load/parallel inputs, counts the shift cycles, and wraps the PISO serial stream into a framed line: start bit, data MSB-first, optional parity, stop bit(s).
- Sits between a word producer and the serial output pin; the PISO itself stays unchanged.

---
 rtl/piso_tx_ctrl_if.sv | 21 ++
 rtl/piso_tx_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/piso_tx_ctrl_if.sv
// Word handshake between a producer and the PISO frame sequencer.
// The producer drives the master side; the sequencer takes the slave side.
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/piso_tx_ctrl.sv
// Frame sequencer for an external PISO: start bit, data MSB-first, stop bit(s).
// Define PISO_TX_PARITY_EN to insert an even-parity bit between data and stop.
module piso_tx_ctrl #(
    parameter int WIDTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    piso_tx_ctrl_if.slave    in_if,
    output logic             piso_load,
    output logic [WIDTH-1:0] piso_data,
    input  logic             piso_sout,
    output logic             tx_line,
    output logic             busy,
    output logic             frame_done
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [2:0]         stop_cnt_q;
    logic               in_ready_q;
    logic               piso_load_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               line_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            in_ready_q   <= 1'b1;
            piso_load_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_q       <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_if.in_valid) begin
                        data_q      <= in_if.in_data;
                        state_q     <= LOAD;
                        in_ready_q  <= 1'b0;
                        piso_load_q <= 1'b1;
                        busy_q      <= 1'b1;
                        line_q      <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q     <= SHIFT;
                    piso_load_q <= 1'b0;
                    bit_cnt_q   <= '0;
                    line_q      <= 1'b1;
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PISO_TX_PARITY_EN
                        state_q <= PARITY;
                        line_q  <= ^data_q;
`else
                        state_q      <= STOP;
                        line_q       <= 1'b1;
                        stop_cnt_q   <= '0;
                        frame_done_q <= (STOP_BITS == 1);
`endif
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    state_q      <= STOP;
                    line_q       <= 1'b1;
                    stop_cnt_q   <= '0;
                    frame_done_q <= (STOP_BITS == 1);
                end
`endif
                STOP: begin
                    if (stop_cnt_q == 3'(STOP_BITS - 1)) begin
                        state_q      <= IDLE;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                    end else begin
                        // Raise the pulse one cycle early so it lands on the last stop cycle.
                        stop_cnt_q   <= stop_cnt_q + 1'b1;
                        frame_done_q <= (stop_cnt_q == 3'(STOP_BITS - 2));
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    in_ready_q   <= 1'b1;
                    piso_load_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                    line_q       <= 1'b1;
                end
            endcase
        end
    end

    // Data bits bypass the line register so the PISO output reaches the pin in the same cycle.
    assign tx_line        = (state_q == SHIFT) ? piso_sout : line_q;
    assign in_if.in_ready = in_ready_q;
    assign piso_load      = piso_load_q;
    assign piso_data      = data_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
endmodule
